// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, exponent constants and the
// conversion-unit state encoding.
package fpu_pkg;
  localparam int FLT_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  // Exponent for a value whose leading one sits at bit 31 of the integer.
  localparam logic [EXP_W-1:0] ITOF_EXP_TOP = EXP_W'(FLT_BIAS + 31);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND} itof_state_t;
endpackage

// File: rtl/itof_if.sv
// en/valid/idle handshake bundle between FPU dispatch and the itof unit.
interface itof_if;
  logic [31:0] x1;
  logic        en;
  logic [31:0] y;
  logic        valid;
  logic        idle;

  modport master (output x1, en, input y, valid, idle);
  modport slave  (input x1, en, output y, valid, idle);
endinterface

// File: rtl/itof_lzc32.sv
// Combinational leading-zero counter, 32-bit input; returns 32 for zero.
module lzc32 (
  input  logic [31:0] a_i,
  output logic [5:0]  cnt_o
);
  // Each tree node keeps an all-zero flag and the leading-zero count within its
  // span; the count is only meaningful when the node is non-zero.
  logic [15:0]      z1;
  logic [15:0][0:0] c1;
  logic [7:0]       z2;
  logic [7:0][1:0]  c2;
  logic [3:0]       z3;
  logic [3:0][2:0]  c3;
  logic [1:0]       z4;
  logic [1:0][3:0]  c4;
  logic             z5;
  logic [4:0]       c5;

  for (genvar i = 0; i < 16; i++) begin : g_l1
    assign z1[i] = ~|a_i[2*i+1 -: 2];
    assign c1[i] = ~a_i[2*i+1];
  end
  for (genvar i = 0; i < 8; i++) begin : g_l2
    assign z2[i] = z1[2*i+1] & z1[2*i];
    assign c2[i] = z1[2*i+1] ? {1'b1, c1[2*i]} : {1'b0, c1[2*i+1]};
  end
  for (genvar i = 0; i < 4; i++) begin : g_l3
    assign z3[i] = z2[2*i+1] & z2[2*i];
    assign c3[i] = z2[2*i+1] ? {1'b1, c2[2*i]} : {1'b0, c2[2*i+1]};
  end
  for (genvar i = 0; i < 2; i++) begin : g_l4
    assign z4[i] = z3[2*i+1] & z3[2*i];
    assign c4[i] = z3[2*i+1] ? {1'b1, c3[2*i]} : {1'b0, c3[2*i+1]};
  end
  assign z5    = z4[1] & z4[0];
  assign c5    = z4[1] ? {1'b1, c4[0]} : {1'b0, c4[1]};
  assign cnt_o = z5 ? 6'd32 : {1'b0, c5};
endmodule

// File: rtl/itof.sv
// Signed int32 -> binary32 converter: capture/abs, normalise, round/pack,
// one result every three cycles on the en/valid/idle handshake.
module itof
  import fpu_pkg::*;
#(
  parameter int ROUND_EVEN = 1
) (
  input  logic   clk,
  input  logic   rst,
  itof_if.slave  bus
);
  itof_state_t        state_q, state_d;
  logic               sign_q, sign_d;
  logic [31:0]        abs_q, abs_d;
  logic               zero_q, zero_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [MAN_W-1:0]   mant_q, mant_d;
  logic               lsb_q, lsb_d, guard_q, guard_d, sticky_q, sticky_d;
  logic [31:0]        y_q, y_d;
  logic               valid_q, valid_d, idle_q, idle_d;

  logic [5:0]         lz;
  logic [31:0]        norm;
  logic               round_up;
  logic [30:0]        packed_sum;

  lzc32 u_lzc (.a_i(abs_q), .cnt_o(lz));

  assign norm       = abs_q << lz;
  assign round_up   = (ROUND_EVEN != 0) ? (guard_q & (sticky_q | lsb_q)) : guard_q;
  // A carry out of the mantissa lands in the exponent field by construction.
  assign packed_sum = {exp_q, mant_q} + 31'(round_up);

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    abs_d    = abs_q;
    zero_d   = zero_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    lsb_d    = lsb_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    y_d      = y_q;
    valid_d  = 1'b0;
    idle_d   = idle_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          sign_d  = bus.x1[31];
          abs_d   = bus.x1[31] ? (~bus.x1 + 32'd1) : bus.x1;
          idle_d  = 1'b0;
          state_d = S_NORM;
        end else begin
          idle_d  = 1'b1;
        end
      end
      S_NORM: begin
        // After normalisation bit 31 is clear only for a zero operand.
        zero_d   = ~norm[31];
        exp_d    = ITOF_EXP_TOP - {2'b00, lz};
        mant_d   = norm[30:8];
        lsb_d    = norm[8];
        guard_d  = norm[7];
        sticky_d = |norm[6:0];
        state_d  = S_ROUND;
      end
      S_ROUND: begin
        y_d     = zero_q ? 32'h0 : {sign_q, packed_sum};
        valid_d = 1'b1;
        idle_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      abs_q    <= '0;
      zero_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      lsb_q    <= 1'b0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      abs_q    <= abs_d;
      zero_q   <= zero_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      lsb_q    <= lsb_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      idle_q   <= idle_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.idle  = idle_q;
endmodule

// File: tb/tb_itof.sv
// Directed bench for itof: both rounding modes side by side, handshake
// timing, busy/reset behaviour and a randomised sweep against an integer model.
module tb_itof;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  itof_if bus_e ();
  itof_if bus_a ();

  itof #(.ROUND_EVEN(1)) dut_e (.clk(clk), .rst(rst), .bus(bus_e));
  itof #(.ROUND_EVEN(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] x, input logic e);
    bus_e.x1 = x; bus_a.x1 = x;
    bus_e.en = e; bus_a.en = e;
  endtask

  // Rounds |x| to 24 significant bits by comparing the discarded remainder
  // against half an ulp.
  function automatic logic [31:0] model(input logic [31:0] x, input bit even);
    logic        s;
    logic [63:0] a, q, rem, half;
    int          m, sh;
    logic [7:0]  e;
    s = x[31];
    a = s ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
    if (a == 64'd0) return 32'h0;
    m = 0;
    for (int i = 0; i < 33; i++) if (a[i]) m = i;
    if (m <= 23) begin
      q = a << (23 - m);
    end else begin
      sh   = m - 23;
      q    = a >> sh;
      rem  = a - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (!even || q[0]))) q = q + 64'd1;
    end
    e = 8'(m + 127);
    if (q == 64'h100_0000) begin
      q = q >> 1;
      e = e + 8'd1;
    end
    return {s, e, q[22:0]};
  endfunction

  // One full transaction with the handshake checked at every cycle.
  task automatic convert(input string tag, input logic [31:0] x,
                         input logic [31:0] exp_e, input logic [31:0] exp_a);
    @(negedge clk) drive(x, 1'b1);
    @(negedge clk) drive($urandom, 1'b0);
    chk({tag, ".idle1"}, {31'h0, bus_e.idle}, 32'd0);
    chk({tag, ".vld1"},  {31'h0, bus_e.valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".idle2"}, {31'h0, bus_e.idle}, 32'd0);
    chk({tag, ".vld2"},  {31'h0, bus_e.valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".vld3"},  {31'h0, bus_e.valid}, 32'd1);
    chk({tag, ".vld3a"}, {31'h0, bus_a.valid}, 32'd1);
    chk({tag, ".idle3"}, {31'h0, bus_e.idle}, 32'd1);
    chk({tag, ".y_even"}, bus_e.y, exp_e);
    chk({tag, ".y_away"}, bus_a.y, exp_a);
    @(negedge clk);
    chk({tag, ".vld4"},  {31'h0, bus_e.valid}, 32'd0);
  endtask

  logic [31:0] vals [3];
  logic [31:0] r;

  initial begin
    // Reset wins over a simultaneous request.
    drive(32'd99, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst.y", bus_e.y, 32'h0);
    chk("rst.valid", {31'h0, bus_e.valid}, 32'd0);
    chk("rst.idle", {31'h0, bus_e.idle}, 32'd1);
    rst = 1'b0;
    drive(32'd0, 1'b0);

    convert("one",   32'd1,           32'h3F800000, 32'h3F800000);
    convert("m_one", 32'hFFFFFFFF,    32'hBF800000, 32'hBF800000);
    convert("d123",  32'd123,         32'h42F60000, 32'h42F60000);
    convert("zero",  32'd0,           32'h00000000, 32'h00000000);
    convert("min",   32'h80000000,    32'hCF000000, 32'hCF000000);
    convert("max",   32'h7FFFFFFF,    32'h4F000000, 32'h4F000000);
    convert("tie_lo", 32'd16777217,   32'h4B800000, 32'h4B800001);
    convert("tie_hi", 32'd16777219,   32'h4B800002, 32'h4B800002);
    convert("tie_neg", -32'sd16777217, 32'hCB800000, 32'hCB800001);
    convert("nontie", 32'd16777218,   32'h4B800001, 32'h4B800001);

    // Requests while busy are dropped, not queued.
    @(negedge clk) drive(32'd7, 1'b1);
    @(negedge clk) drive(32'd9, 1'b1);
    @(negedge clk) drive(32'd11, 1'b1);
    @(negedge clk);
    chk("busy.y", bus_e.y, 32'h40E00000);
    chk("busy.valid", {31'h0, bus_e.valid}, 32'd1);
    drive(32'd13, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("busy.no_2nd", {31'h0, bus_e.valid}, 32'd0);
      chk("busy.idle", {31'h0, bus_e.idle}, 32'd1);
    end

    // Back-to-back: en held high, only the accepting-edge x1 matters.
    vals[0] = 32'd1000; vals[1] = -32'sd42; vals[2] = 32'd16777219;
    @(negedge clk) drive(vals[0], 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b.idle", {31'h0, bus_e.idle}, 32'd0);
      drive($urandom, 1'b1);
      @(negedge clk);
      chk("b2b.vld_lo", {31'h0, bus_e.valid}, 32'd0);
      drive($urandom, 1'b1);
      @(negedge clk);
      chk("b2b.vld_hi", {31'h0, bus_e.valid}, 32'd1);
      chk("b2b.y", bus_e.y, model(vals[k], 1'b1));
      if (k < 2) drive(vals[k+1], 1'b1);
      else       drive(32'd0, 1'b0);
    end
    @(negedge clk);
    chk("b2b.end_vld", {31'h0, bus_e.valid}, 32'd0);
    chk("b2b.end_idle", {31'h0, bus_e.idle}, 32'd1);

    // Reset during normalisation aborts without a valid pulse.
    @(negedge clk) drive(32'd5, 1'b1);
    @(negedge clk) drive(32'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.idle", {31'h0, bus_e.idle}, 32'd1);
    chk("abort.valid", {31'h0, bus_e.valid}, 32'd0);
    chk("abort.y", bus_e.y, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("abort.no_pulse", {31'h0, bus_e.valid}, 32'd0);
    end
    convert("after_abort", 32'd5, 32'h40A00000, 32'h40A00000);

    // Random operands of varied magnitude and sign.
    for (int n = 0; n < 300; n++) begin
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = ~r + 32'd1;
      convert("rand", r, model(r, 1'b1), model(r, 1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
